// File: rtl/genius_pkg.sv
// Shared definitions for the Genius playback path: state encoding, colour/LED
// mapping, speed codes and default step timing.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_RED    = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_BLUE   = 2'd3;

  localparam logic [1:0] SPEED_V1 = 2'd1;
  localparam logic [1:0] SPEED_V2 = 2'd2;

  localparam int DEF_MAX_LEN        = 32;
  localparam int DEF_STEP_CYCLES_V1 = 33554432;
  localparam int DEF_STEP_CYCLES_V2 = 67108864;

  function automatic logic [3:0] colour_to_led(input logic [1:0] colour);
    logic [3:0] led;
    case (colour)
      COL_GREEN:  led = 4'b0001;
      COL_RED:    led = 4'b0010;
      COL_YELLOW: led = 4'b0100;
      COL_BLUE:   led = 4'b1000;
      default:    led = 4'b0000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Shared by sequence playback and the upcoming input-timeout logic.
module step_timer
  import genius_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n)
      r_count <= '0;
    else if (load)
      r_count <= load_value;
    else if (r_count != '0)
      r_count <= r_count - 1'b1;
  end

  assign expire = (r_count == '0);

endmodule

// File: rtl/genius_sequence_player.sv
// Plays the stored colour sequence on the LEDs: each step is lit for P clocks,
// then dark for P clocks; done pulses once the last gap ends.
//  state | meaning
//  IDLE  | waiting for start
//  FETCH | read colour at index, arm timer
//  SHOW  | LED lit for P cycles
//  GAP   | LED dark for P cycles, then advance
//  DONE  | one-cycle completion pulse
module genius_sequence_player
  import genius_pkg::*;
#(
  parameter int MAX_LEN        = DEF_MAX_LEN,
  parameter int STEP_CYCLES_V1 = DEF_STEP_CYCLES_V1,
  parameter int STEP_CYCLES_V2 = DEF_STEP_CYCLES_V2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 velocidade,
  input  logic [5:0]                 seq_len,
  output logic [$clog2(MAX_LEN)-1:0] rd_addr,
  input  logic [1:0]                 rd_data,
  output logic [3:0]                 led,
  output logic                       busy,
  output logic                       done
);

  localparam int AW       = $clog2(MAX_LEN);
  localparam int IW       = AW + 1;
  localparam int STEP_MAX = (STEP_CYCLES_V1 > STEP_CYCLES_V2) ? STEP_CYCLES_V1 : STEP_CYCLES_V2;
  localparam int TW       = $clog2(STEP_MAX);

  state_t          r_state;
  state_t          w_next;
  logic            r_slow;
  logic [IW-1:0]   r_index;
  logic [IW-1:0]   r_len;
  logic [1:0]      r_colour;
  logic [IW-1:0]   w_len_in;
  logic [TW-1:0]   w_step_m1;
  logic            w_load;
  logic            w_expire;
  logic            w_last;

  assign w_len_in  = (int'(seq_len) > MAX_LEN) ? IW'(MAX_LEN) : IW'(seq_len);
  assign w_step_m1 = r_slow ? TW'(STEP_CYCLES_V2 - 1) : TW'(STEP_CYCLES_V1 - 1);
  assign w_last    = ((r_index + 1'b1) == r_len);
  assign rd_addr   = r_index[AW-1:0];

  step_timer #(.W(TW)) u_step_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_load),
    .load_value (w_step_m1),
    .expire     (w_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (w_len_in == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: w_next = ST_SHOW;
      ST_SHOW:  if (w_expire) w_next = ST_GAP;
      ST_GAP:   if (w_expire) w_next = w_last ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    // abort outranks every timer-driven transition
    if (abort && r_state != ST_IDLE)
      w_next = ST_IDLE;
  end

  always_comb begin
    w_load = 1'b0;
    led    = 4'b0000;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_load = 1'b1;
        busy   = 1'b1;
      end
      ST_SHOW: begin
        w_load = w_expire;
        busy   = 1'b1;
        led    = colour_to_led(r_colour);
      end
      ST_GAP:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_slow   <= 1'b0;
      r_len    <= '0;
      r_index  <= '0;
      r_colour <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_slow  <= (velocidade == SPEED_V2);
          r_len   <= w_len_in;
          r_index <= '0;
        end
        ST_FETCH: r_colour <= rd_data;
        ST_GAP:   if (w_expire && !abort) r_index <= r_index + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_genius_sequence_player.sv
// Bench for genius_sequence_player: expected LED/busy/done/rd_addr per cycle are
// derived from the step-timing formulas (cycle 1 + k*(2P+1) is the fetch of step k).
module tb_genius_sequence_player;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] velocidade = 2'd0;
  logic [5:0] seq_len = 6'd0;
  logic [4:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [1:0] mem [32];
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign rd_data = mem[rd_addr];

  genius_sequence_player #(
    .MAX_LEN        (32),
    .STEP_CYCLES_V1 (4),
    .STEP_CYCLES_V2 (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .velocidade (velocidade),
    .seq_len    (seq_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // One playback: start sampled at cycle 0, outputs compared on every following
  // negedge. abort_at/reset_at cut the run; busy_start_at pulses start mid-run;
  // switch_at changes velocidade and seq_len mid-run (all -1 when unused).
  task automatic play(input int slen, input logic [1:0] vel, input int abort_at,
                      input int reset_at, input int busy_start_at, input int switch_at);
    int L, P, per, endc, cut, last, k, off;
    logic [3:0] e_led, one;
    logic e_busy, e_done;
    L    = (slen > 32) ? 32 : slen;
    P    = (vel == 2'd2) ? 8 : 4;
    per  = 2 * P + 1;
    endc = 1 + L * per;
    cut  = (abort_at >= 0) ? abort_at : reset_at;
    last = (cut >= 0) ? cut + 1 : endc + 1;
    one  = 4'b0001;
    @(negedge clock);
    seq_len    = 6'(slen);
    velocidade = vel;
    start      = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clock);
      e_led = 4'b0000; e_busy = 1'b0; e_done = 1'b0;
      if (cut >= 0 && c > cut) begin
        if (reset_at >= 0) check("rd_addr_after_reset", c, 8'(rd_addr), 8'd0);
      end else if (L == 0) begin
        e_done = (c == 1);
      end else if (c < endc) begin
        k = (c - 1) / per;
        off = (c - 1) % per;
        e_busy = 1'b1;
        if (off >= 1 && off <= P) e_led = one << mem[k];
        if (off == 0) check("rd_addr_fetch", c, 8'(rd_addr), 8'(k));
      end else if (c == endc) begin
        e_done = 1'b1;
      end
      check("led", c, 8'(led), 8'(e_led));
      check("busy", c, 8'(busy), 8'(e_busy));
      check("done", c, 8'(done), 8'(e_done));
      abort   = (c == abort_at);
      reset_n = !(c == reset_at);
      start   = (c == busy_start_at);
      if (c == switch_at) begin
        velocidade = 2'd1;
        seq_len    = 6'd1;
      end
    end
    abort   = 1'b0;
    reset_n = 1'b1;
    start   = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;

    // reset held for three cycles
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_led", 0, 8'(led), 8'd0);
    check("reset_busy", 0, 8'(busy), 8'd0);
    check("reset_done", 0, 8'(done), 8'd0);
    check("reset_rd_addr", 0, 8'(rd_addr), 8'd0);

    // directed sequence {green, blue, red}
    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
    play(3, 2'd1, -1, -1, -1, -1);
    // slow speed, with velocidade/seq_len changed mid-run
    play(3, 2'd2, -1, -1, -1, 20);
    // empty sequence
    play(0, 2'd1, -1, -1, -1, -1);
    // oversize length clamps to 32 steps
    fill_random();
    play(40, 2'd0, -1, -1, -1, -1);
    // abort in the second SHOW, then restart two cycles later
    mem[0] = 2'd2; mem[1] = 2'd3; mem[2] = 2'd1;
    play(3, 2'd1, 12, -1, -1, -1);
    play(3, 2'd1, -1, -1, -1, -1);
    // start pulsed while busy is ignored
    play(3, 2'd3, -1, -1, 15, -1);
    // reset during the first GAP
    play(3, 2'd1, -1, 7, -1, -1);
    // randomized runs
    for (int r = 0; r < 4; r++) begin
      fill_random();
      play(int'($urandom_range(1, 12)), 2'($urandom_range(0, 3)), -1, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
